calc_cmd_issuer: RTL

CALC_CMD_ISSUER -- requirements
Module: calc_cmd_issuer

---
 rtl/calc_pkg.sv | 42 ++++
 rtl/calc_rsp_fifo.sv | 51 +++++
 rtl/calc_cmd_issuer.sv | 115 +++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator command issuer.
package calc_pkg;

  localparam logic [3:0] MODE_ADD  = 4'd0;
  localparam logic [3:0] MODE_SUB  = 4'd1;
  localparam logic [3:0] MODE_MUL  = 4'd2;
  localparam logic [3:0] MODE_DIV  = 4'd3;
  localparam logic [3:0] MODE_IDLE = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2
  } issuer_state_e;

  typedef struct packed {
    logic [63:0] result;
    logic [7:0]  tag;
    logic        err;
  } calc_rsp_t;

  // Applies the error rules on top of the raw calculator result.
  function automatic calc_rsp_t make_rsp(input logic [3:0]  mode,
                                         input logic [63:0] b,
                                         input logic [63:0] result,
                                         input logic [7:0]  tag);
    calc_rsp_t r;
    r.tag = tag;
    if (mode > MODE_DIV) begin
      r.result = '0;
      r.err    = 1'b1;
    end else if (mode == MODE_DIV && b == '0) begin
      r.result = '1;
      r.err    = 1'b1;
    end else begin
      r.result = result;
      r.err    = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/calc_rsp_fifo.sv
// Response buffer: small circular FIFO of calc_rsp_t entries.
module calc_rsp_fifo import calc_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  calc_rsp_t push_data_i,
  input  logic      pop_i,
  output calc_rsp_t head_o,
  output logic      empty_o,
  output logic      full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  calc_rsp_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  // Payload reads as zero when nothing is buffered so reset/empty state is clean.
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are only observable through a valid count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/calc_cmd_issuer.sv
// Issues one command at a time to a combinational calculator, waits for the
// result to settle, and queues tagged responses in order.
module calc_cmd_issuer import calc_pkg::*; #(
  parameter int SETTLE_CYCLES = 2,
  parameter int RSP_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [63:0] cmd_a,
  input  logic [63:0] cmd_b,
  input  logic [3:0]  cmd_mode,
  input  logic [7:0]  cmd_tag,
  output logic [63:0] calc_a,
  output logic [63:0] calc_b,
  output logic [3:0]  calc_mode,
  input  logic [63:0] calc_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_result,
  output logic [7:0]  rsp_tag,
  output logic        rsp_err,
  output logic        busy
);

  issuer_state_e state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [63:0]   a_q, a_d, b_q, b_d;
  logic [3:0]    mode_q, mode_d;
  logic [7:0]    tag_q, tag_d;
  logic          rdy_en_q;
  logic          accept, push, fifo_empty, fifo_full;
  calc_rsp_t     push_data, head;

  // rdy_en_q keeps cmd_ready low until the first edge after reset release.
  assign cmd_ready = rdy_en_q && (state_q == IDLE) && !fifo_full;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_q != IDLE);
  assign calc_a    = a_q;
  assign calc_b    = b_q;
  assign calc_mode = mode_q;
  assign push_data = make_rsp(mode_q, b_q, calc_result, tag_q);

  // Next-state and operand register updates for the issue sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    tag_d   = tag_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = cmd_a;
          b_d     = cmd_b;
          mode_d  = cmd_mode;
          tag_d   = cmd_tag;
          cnt_d   = 4'(SETTLE_CYCLES - 1);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = CAPTURE;
        else             cnt_d   = cnt_q - 4'd1;
      end
      CAPTURE: begin
        push    = 1'b1;
        mode_d  = MODE_IDLE;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and calculator-facing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= MODE_IDLE;
      tag_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      tag_q    <= tag_d;
      rdy_en_q <= 1'b1;
    end
  end

  calc_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (rsp_ready),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  assign rsp_valid  = !fifo_empty;
  assign rsp_result = head.result;
  assign rsp_tag    = head.tag;
  assign rsp_err    = head.err;

endmodule
